// File: rtl/param_dp_ram_pkg.sv
// rtl/param_dp_ram_pkg.sv - shared state type and default parameters for param_dp_ram
package param_dp_ram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   localparam int DEF_DATA_W       = 8;
   localparam int DEF_ADDR_W       = 4;
   localparam int DEF_WR_FIRST     = 1;
   localparam int DEF_CLR_ON_RESET = 1;

endpackage

// File: rtl/param_dp_ram_core.sv
// rtl/param_dp_ram_core.sv - DEPTH x DATA_W storage array, one write port, one read port
module dp_ram_core #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Read is combinational so the caller sees pre-write contents on a same-edge collision.
   assign rdata = mem[raddr];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

endmodule

// File: rtl/param_dp_ram.sv
// rtl/param_dp_ram.sv - dual-port RAM with clear sweep FSM, collision mux and registered read
module param_dp_ram
   import param_dp_ram_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int WR_FIRST     = DEF_WR_FIRST,
   parameter int CLR_ON_RESET = DEF_CLR_ON_RESET
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] din,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] dout,
   output logic              rd_valid,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

   state_t            state;
   logic [ADDR_W-1:0] clr_cnt;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              collide;

   // The sweep owns the write port while clearing; user strobes are dropped.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = wr_addr;
      mem_wdata = din;
      if (state == CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = clr_cnt;
         mem_wdata = '0;
      end else begin
         mem_we    = wr_en;
      end
   end

   assign collide = (WR_FIRST != 0) && wr_en && (wr_addr == rd_addr);

   dp_ram_core #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_core (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .raddr (rd_addr),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= (CLR_ON_RESET != 0) ? CLEAR : READY;
         clr_cnt  <= '0;
         dout     <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         case (state)
            CLEAR: begin
               if (clr_cnt == LAST_ADDR) begin
                  state   <= READY;
                  clr_cnt <= '0;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            READY: begin
               if (rd_en) begin
                  dout     <= collide ? din : mem_rdata;
                  rd_valid <= 1'b1;
               end
               if (clr) begin
                  state   <= CLEAR;
                  clr_cnt <= '0;
               end
            end
            default: state <= READY;
         endcase
      end
   end

   assign busy = (state == CLEAR);

endmodule

// File: tb/tb_param_dp_ram.sv
// tb/tb_param_dp_ram.sv - directed self-checking bench for param_dp_ram
module tb_param_dp_ram;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
   logic [3:0] wr_addr = '0, rd_addr = '0;
   logic [7:0] din = '0;
   logic [7:0] dout;
   logic       rd_valid, busy;

   logic       b_wr_en = 1'b0, b_rd_en = 1'b0;
   logic [3:0] b_wr_addr = '0, b_rd_addr = '0;
   logic [7:0] b_din = '0;
   logic [7:0] b_dout;
   logic       b_rd_valid, b_busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   param_dp_ram dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
      .din(din), .rd_en(rd_en), .rd_addr(rd_addr), .dout(dout),
      .rd_valid(rd_valid), .busy(busy)
   );

   param_dp_ram #(.WR_FIRST(0), .CLR_ON_RESET(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .clr(1'b0), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
      .din(b_din), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .dout(b_dout),
      .rd_valid(b_rd_valid), .busy(b_busy)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      b_wr_en = 1'b0; b_rd_en = 1'b0;
   endtask

   task automatic count_busy(input string name);
      int n;
      n = 0;
      while (busy && n < 40) begin
         n++;
         cyc();
      end
      n_checks++;
      if (n !== 16) begin
         n_fail++;
         $display("FAIL %s busy_cycles actual=%0d required=16", name, n);
      end
   endtask

   task automatic read_all_zero(input string name);
      for (int i = 0; i < 16; i++) begin
         rd_en = 1'b1; rd_addr = 4'(i);
         cyc();
         n_checks++;
         if (rd_valid !== 1'b1 || dout !== 8'h00) begin
            n_fail++;
            $display("FAIL %s addr=%0d actual dout=%h valid=%b required dout=00 valid=1",
                     name, i, dout, rd_valid);
         end
      end
      idle();
      cyc();
      n_checks++;
      if (rd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s valid_drop actual=%b required=0", name, rd_valid);
      end
   endtask

   task automatic test_reset();
      #12;
      n_checks++;
      if (dout !== 8'h00 || rd_valid !== 1'b0 || busy !== 1'b1 || b_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state actual dout=%h valid=%b busy=%b b_busy=%b required 00/0/1/0",
                  dout, rd_valid, busy, b_busy);
      end
      cyc();
      rst_n = 1'b1;
      count_busy("reset_sweep");
      read_all_zero("reset_zero");
   endtask

   task automatic test_write_read();
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_addr = 4'(i); din = 8'hA0 + 8'(i);
         cyc();
      end
      idle();
      for (int i = 0; i < 16; i++) begin
         rd_en = 1'b1; rd_addr = 4'(i);
         cyc();
         n_checks++;
         if (rd_valid !== 1'b1 || dout !== 8'hA0 + 8'(i)) begin
            n_fail++;
            $display("FAIL write_read addr=%0d actual dout=%h valid=%b required dout=%h valid=1",
                     i, dout, rd_valid, 8'hA0 + 8'(i));
         end
      end
      idle();
      cyc();
   endtask

   task automatic test_collision();
      wr_en = 1'b1; wr_addr = 4'd5; din = 8'h11;
      b_wr_en = 1'b1; b_wr_addr = 4'd5; b_din = 8'h11;
      cyc();
      wr_en = 1'b1; wr_addr = 4'd5; din = 8'h22; rd_en = 1'b1; rd_addr = 4'd5;
      b_wr_en = 1'b1; b_wr_addr = 4'd5; b_din = 8'h22; b_rd_en = 1'b1; b_rd_addr = 4'd5;
      cyc();
      n_checks++;
      if (dout !== 8'h22 || rd_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL collision_wr_first actual=%h required=22", dout);
      end
      n_checks++;
      if (b_dout !== 8'h11 || b_rd_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL collision_rd_first actual=%h required=11", b_dout);
      end
      idle();
      rd_en = 1'b1; rd_addr = 4'd5; b_rd_en = 1'b1; b_rd_addr = 4'd5;
      wr_en = 1'b1; wr_addr = 4'd6; din = 8'h66;
      cyc();
      n_checks++;
      if (dout !== 8'h22 || b_dout !== 8'h22) begin
         n_fail++;
         $display("FAIL collision_later actual=%h/%h required=22/22", dout, b_dout);
      end
      idle();
      rd_en = 1'b1; rd_addr = 4'd6;
      cyc();
      n_checks++;
      if (dout !== 8'h66) begin
         n_fail++;
         $display("FAIL diff_addr_write actual=%h required=66", dout);
      end
      idle();
      cyc();
   endtask

   task automatic test_clear();
      clr = 1'b1; wr_en = 1'b1; wr_addr = 4'd3; din = 8'h33; rd_en = 1'b1; rd_addr = 4'd3;
      cyc();
      n_checks++;
      if (dout !== 8'h33 || rd_valid !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL clr_same_cycle actual dout=%h valid=%b busy=%b required 33/1/1",
                  dout, rd_valid, busy);
      end
      begin
         int n;
         n = 0;
         while (busy && n < 40) begin
            n++;
            clr = 1'b1; wr_en = 1'b1; wr_addr = 4'(n); din = 8'h55; rd_en = 1'b1; rd_addr = 4'(n);
            cyc();
            if (busy) begin
               n_checks++;
               if (rd_valid !== 1'b0 || dout !== 8'h33) begin
                  n_fail++;
                  $display("FAIL clear_ignore cyc=%0d actual dout=%h valid=%b required 33/0",
                           n, dout, rd_valid);
               end
            end
         end
         idle();
         n_checks++;
         if (n !== 16) begin
            n_fail++;
            $display("FAIL clear_busy_cycles actual=%0d required=16", n);
         end
      end
      read_all_zero("clear_zero");
   endtask

   task automatic test_reset_mid_sweep();
      wr_en = 1'b1; wr_addr = 4'd2; din = 8'h77;
      cyc();
      idle();
      rd_en = 1'b1; rd_addr = 4'd2;
      cyc();
      idle();
      clr = 1'b1;
      cyc();
      idle();
      repeat (7) cyc();
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (dout !== 8'h00 || rd_valid !== 1'b0 || busy !== 1'b1 || b_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset actual dout=%h valid=%b busy=%b b_busy=%b required 00/0/1/0",
                  dout, rd_valid, busy, b_busy);
      end
      cyc();
      rst_n = 1'b1;
      count_busy("mid_reset_sweep");
      read_all_zero("mid_reset_zero");
   endtask

   task automatic test_no_clear_variant();
      n_checks++;
      if (b_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b_busy actual=%b required=0", b_busy);
      end
      b_wr_en = 1'b1; b_wr_addr = 4'd15; b_din = 8'hFF;
      cyc();
      idle();
      b_rd_en = 1'b1; b_rd_addr = 4'd15;
      cyc();
      n_checks++;
      if (b_dout !== 8'hFF || b_rd_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL b_addr15 actual dout=%h valid=%b required FF/1", b_dout, b_rd_valid);
      end
      idle();
      cyc();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_collision();
      test_clear();
      test_reset_mid_sweep();
      test_no_clear_variant();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
